// File: rtl/mem_wb_pkg.sv
// Shared types and width helpers for the MEM->WB pipeline register.
package mem_wb_pkg;

   localparam int DATA_W_D = 32;
   localparam int PC_W_D   = 32;
   localparam int DEST_W_D = 5;

   typedef struct packed {
      logic                wb_en;
      logic                mem_r_en;
      logic [DATA_W_D-1:0] alu_result;
      logic [DATA_W_D-1:0] mem_read_value;
      logic [DEST_W_D-1:0] dest;
      logic [PC_W_D-1:0]   pc;
   } mem_wb_payload_t;

   localparam int PAYLOAD_W_D = $bits(mem_wb_payload_t);

   // Payload width for non-default field widths; field order matches mem_wb_payload_t.
   function automatic int payload_w(input int data_w, input int pc_w, input int dest_w);
      return 2 + 2 * data_w + dest_w + pc_w;
   endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-slot valid/ready skid buffer on an opaque payload; ready is registered.
module skid_buffer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_vld, skid_vld;
   logic [W-1:0] main_dat, skid_dat;
   logic         accept, consume;

   assign in_ready  = ~skid_vld;
   assign out_valid = main_vld;
   assign out_data  = main_dat;
   assign accept    = in_valid & ~skid_vld;
   assign consume   = main_vld & out_ready;

   // Invalid slots always hold zero data so downstream never sees stale payload.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_vld <= 1'b0;
         main_dat <= '0;
         skid_vld <= 1'b0;
         skid_dat <= '0;
      end else if (flush) begin
         main_vld <= 1'b0;
         main_dat <= '0;
         skid_vld <= 1'b0;
         skid_dat <= '0;
      end else if (skid_vld && consume) begin
         main_vld <= 1'b1;
         main_dat <= skid_dat;
         skid_vld <= 1'b0;
         skid_dat <= '0;
      end else if (accept && (!main_vld || consume)) begin
         main_vld <= 1'b1;
         main_dat <= in_data;
      end else if (accept) begin
         skid_vld <= 1'b1;
         skid_dat <= in_data;
      end else if (consume) begin
         main_vld <= 1'b0;
         main_dat <= '0;
      end
   end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with skid-buffered handshake, flush and bubble-safe controls.
// Optional stall/flush performance counters under PIPE_REG_PERF_EN.
module mem_wb_pipe_reg
   import mem_wb_pkg::*;
#(
   parameter int DATA_W = DATA_W_D,
   parameter int PC_W   = PC_W_D,
   parameter int DEST_W = DEST_W_D,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_wb_en,
   input  logic              in_mem_r_en,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_mem_read_value,
   input  logic [DEST_W-1:0] in_dest,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_wb_en,
   output logic              out_mem_r_en,
   output logic [DATA_W-1:0] out_alu_result,
   output logic [DATA_W-1:0] out_mem_read_value,
   output logic [DEST_W-1:0] out_dest,
   output logic [PC_W-1:0]   out_pc
`ifdef PIPE_REG_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   localparam int W = payload_w(DATA_W, PC_W, DEST_W);

   logic [W-1:0] in_pl, out_pl;
   logic         pl_wb_en, pl_mem_r_en;

   assign in_pl = {in_wb_en, in_mem_r_en, in_alu_result, in_mem_read_value, in_dest, in_pc};

   skid_buffer #(.W(W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_pl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_pl)
   );

   assign {pl_wb_en, pl_mem_r_en, out_alu_result, out_mem_read_value, out_dest, out_pc} = out_pl;

   // Control bits gated by valid so a bubble can never write the register file.
   assign out_wb_en    = out_valid & pl_wb_en;
   assign out_mem_r_en = out_valid & pl_mem_r_en;

`ifdef PIPE_REG_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
         if (flush && !(&flush_cnt))                   flush_cnt <= flush_cnt + 1'b1;
      end
   end
`else
   logic unused_cnt_w;
   assign unused_cnt_w = ^CNT_W;
`endif

endmodule
